// File: rtl/gsim_pkg.sv
// Shared definitions for the banded Gauss-Seidel solver: FSM encoding,
// Q16.16 datapath widths, band coefficients and a small delta helper.
package gsim_pkg;

  localparam int unsigned B_W   = 16;  // b_i integer width
  localparam int unsigned FRAC  = 16;  // Q16.16 fraction bits
  localparam int unsigned X_W   = 32;  // x_i width
  localparam int unsigned ACC_W = 40;  // numerator width, no overflow possible

  // Band matrix: diag 20, +-1 -> -13, +-2 -> 6, +-3 -> -1
  localparam int unsigned COEF_D = 20;
  localparam int unsigned COEF_1 = 13;
  localparam int unsigned COEF_2 = 6;
  localparam int unsigned COEF_3 = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    DWAIT = 3'd3,
    WRITE = 3'd4,
    CHECK = 3'd5,
    SEND  = 3'd6
  } state_t;

  // |a - b| without overflow, one bit wider than the operands
  function automatic logic [X_W:0] abs_diff(input logic signed [X_W-1:0] a,
                                            input logic signed [X_W-1:0] b);
    logic signed [X_W:0] d;
    d = (X_W+1)'(a) - (X_W+1)'(b);
    return d[X_W] ? (X_W+1)'(-d) : (X_W+1)'(d);
  endfunction

endpackage

// File: rtl/gsim_div20_pipe.sv
// Pipelined exact floor((n+10)/20) with saturation to signed 32 bits.
// Ports: clk; in = signed ACC_W numerator; out = signed 32-bit quotient,
// valid DIV_LAT cycles after in is presented. No reset, no handshake.
module gsim_div20_pipe #(
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned DIV_LAT = 2
) (
  input  logic                    clk,
  input  logic signed [ACC_W-1:0] in,
  output logic signed [31:0]      out
);

  localparam int unsigned T_W = ACC_W + 1;
  localparam logic signed [T_W-1:0] DIVISOR = T_W'(gsim_pkg::COEF_D);
  localparam logic signed [T_W-1:0] HALF    = T_W'(gsim_pkg::COEF_D / 2);
  localparam logic signed [T_W-1:0] ONE     = T_W'(1);
  localparam logic signed [T_W-1:0] SAT_MAX = T_W'(64'sh7FFF_FFFF);
  localparam logic signed [T_W-1:0] SAT_MIN = -SAT_MAX - ONE;

  logic signed [T_W-1:0] num_c;
  logic signed [T_W-1:0] quo_c;
  logic signed [T_W-1:0] rem_c;
  logic signed [T_W-1:0] flr_c;
  logic signed [31:0]    sat_c;
  logic signed [31:0]    pipe_q [DIV_LAT];

  // Truncating divide, then step down for negative inexact results to get floor
  always_comb begin
    num_c = T_W'(in) + HALF;
    quo_c = num_c / DIVISOR;
    rem_c = num_c % DIVISOR;
    flr_c = quo_c;
    if (rem_c != '0 && num_c[T_W-1]) begin
      flr_c = quo_c - ONE;
    end
    if (flr_c > SAT_MAX) begin
      sat_c = 32'sh7FFF_FFFF;
    end else if (flr_c < SAT_MIN) begin
      sat_c = 32'sh8000_0000;
    end else begin
      sat_c = flr_c[31:0];
    end
  end

  // Latency pipe; contents are don't-care after reset
  always_ff @(posedge clk) begin
    pipe_q[0] <= sat_c;
    for (int unsigned k = 1; k < DIV_LAT; k++) begin
      pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign out = pipe_q[DIV_LAT-1];

endmodule

// File: rtl/gsim_param.sv
// Gauss-Seidel solver for the 7-diagonal band system A*x = b.
// Loads N signed 16-bit b values (valid/ready), sweeps until the largest
// per-sweep |delta x| <= TOL or MAX_ITER sweeps, then streams N Q16.16
// x values (valid/ready, out_last on x_{N-1}) with iters/converged.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/b_in;
// out_valid/out_ready/x_out/out_last; iters; converged.
module gsim_param
  import gsim_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned MAX_ITER = 70,
  parameter int unsigned TOL      = 0,
  parameter int unsigned DIV_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [B_W-1:0] b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [X_W-1:0] x_out,
  output logic                  out_last,
  output logic [7:0]            iters,
  output logic                  converged
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned DW    = X_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  logic [7:0]              wait_cnt;
  logic [DW-1:0]           max_delta;
  logic [DW-1:0]           delta_c;
  logic signed [B_W-1:0]   b_mem [N];
  logic signed [X_W-1:0]   x_mem [N];
  logic signed [ACC_W-1:0] xm [1:3];
  logic signed [ACC_W-1:0] xp [1:3];
  logic signed [ACC_W-1:0] num_c;
  logic signed [X_W-1:0]   div_out;

  assign idx_nxt = idx + 1'b1;

  // Neighbour fetch (zero outside 0..N-1) and numerator for unknown idx
  always_comb begin
    for (int k = 1; k <= 3; k++) begin
      xm[k] = '0;
      xp[k] = '0;
      if (int'(idx) >= k) begin
        xm[k] = ACC_W'(x_mem[IDX_W'(int'(idx) - k)]);
      end
      if (int'(idx) + k < int'(N)) begin
        xp[k] = ACC_W'(x_mem[IDX_W'(int'(idx) + k)]);
      end
    end
    num_c = (ACC_W'(b_mem[idx]) <<< FRAC)
          + $signed(ACC_W'(COEF_1)) * (xm[1] + xp[1])
          - $signed(ACC_W'(COEF_2)) * (xm[2] + xp[2])
          + $signed(ACC_W'(COEF_3)) * (xm[3] + xp[3]);
    delta_c = abs_diff(div_out, x_mem[idx]);
  end

  gsim_div20_pipe #(
    .ACC_W   (ACC_W),
    .DIV_LAT (DIV_LAT)
  ) u_div (
    .clk (clk),
    .in  (num_c),
    .out (div_out)
  );

  // Control FSM and storage; numerator stays constant through DWAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      x_out     <= '0;
      iters     <= '0;
      converged <= 1'b0;
      idx       <= '0;
      wait_cnt  <= '0;
      max_delta <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        x_mem[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          for (int unsigned k = 0; k < N; k++) begin
            x_mem[k] <= '0;
          end
          idx       <= '0;
          iters     <= '0;
          converged <= 1'b0;
          max_delta <= '0;
          in_ready  <= 1'b1;
          state     <= LOAD;
        end

        LOAD: begin
          if (in_valid) begin
            b_mem[idx] <= b_in;
            if (idx == LAST_IDX) begin
              in_ready <= 1'b0;
              idx      <= '0;
              state    <= CALC;
            end else begin
              idx <= idx_nxt;
            end
          end
        end

        CALC: begin
          wait_cnt <= '0;
          state    <= DWAIT;
        end

        DWAIT: begin
          if (wait_cnt == 8'(DIV_LAT - 1)) begin
            state <= WRITE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        WRITE: begin
          x_mem[idx] <= div_out;
          if (delta_c > max_delta) begin
            max_delta <= delta_c;
          end
          if (idx == LAST_IDX) begin
            state <= CHECK;
          end else begin
            idx   <= idx_nxt;
            state <= CALC;
          end
        end

        CHECK: begin
          iters <= iters + 8'd1;
          idx   <= '0;
          if (max_delta <= DW'(TOL) || iters + 8'd1 == 8'(MAX_ITER)) begin
            converged <= (max_delta <= DW'(TOL));
            out_valid <= 1'b1;
            x_out     <= x_mem[0];
            out_last  <= 1'b0;
            state     <= SEND;
          end else begin
            max_delta <= '0;
            state     <= CALC;
          end
        end

        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              idx      <= idx_nxt;
              x_out    <= x_mem[idx_nxt];
              out_last <= (idx_nxt == LAST_IDX);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_param.sv
// Randomized self-checking bench for gsim_param against an arithmetic
// Gauss-Seidel model (exact floor division) plus a real-valued solve.
module tb_gsim_param;

  localparam int N        = 16;
  localparam int MAX_ITER = 70;
  localparam int TOL      = 0;
  localparam int DIV_LAT  = 2;
  localparam int BOUND    = 12000;
  localparam longint XMAX = 64'sd2147483647;
  localparam longint XMIN = -XMAX - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] b_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] x_out;
  logic               out_last;
  logic [7:0]         iters;
  logic               converged;

  int     checks   = 0;
  int     failures = 0;
  int     b_arr   [N];
  longint exp_x   [N];
  int     exp_iters;
  int     exp_conv;
  real    ref_x   [N];
  bit     use_ref = 1'b0;
  longint w_off   [7] = '{1, -6, 13, 0, 13, -6, 1};

  always #5 clk = ~clk;

  gsim_param #(
    .N        (N),
    .MAX_ITER (MAX_ITER),
    .TOL      (TOL),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .out_last  (out_last),
    .iters     (iters),
    .converged (converged)
  );

  task automatic check(input string tag, input longint obs, input longint want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, want);
    end
  endtask

  function automatic longint div20(input longint n);
    longint t, q;
    t = n + 10;
    if (t >= 0) q = t / 20;
    else        q = -((-t + 19) / 20);
    if (q > XMAX) q = XMAX;
    if (q < XMIN) q = XMIN;
    return q;
  endfunction

  // Gauss-Seidel sweeps straight from the update rule
  task automatic model_solve();
    longint x [N];
    longint n, d, maxd;
    foreach (x[i]) x[i] = 0;
    exp_conv  = 0;
    exp_iters = 0;
    for (int it = 1; it <= MAX_ITER; it++) begin
      maxd = 0;
      for (int i = 0; i < N; i++) begin
        n = longint'(b_arr[i]) * 65536;
        for (int k = -3; k <= 3; k++)
          if (k != 0 && i + k >= 0 && i + k < N) n += w_off[k+3] * x[i+k];
        n = div20(n);
        d = (n > x[i]) ? n - x[i] : x[i] - n;
        if (d > maxd) maxd = d;
        x[i] = n;
      end
      exp_iters = it;
      if (maxd <= TOL) begin
        exp_conv = 1;
        break;
      end
    end
    foreach (x[i]) exp_x[i] = x[i];
  endtask

  // Real-valued solve iterated to full precision, scaled to Q16.16
  task automatic ref_solve();
    real xr [N];
    real s;
    foreach (xr[i]) xr[i] = 0.0;
    repeat (4000) begin
      for (int i = 0; i < N; i++) begin
        s = real'(b_arr[i]);
        for (int k = -3; k <= 3; k++)
          if (k != 0 && i + k >= 0 && i + k < N) s += real'(w_off[k+3]) * xr[i+k];
        xr[i] = s / 20.0;
      end
    end
    foreach (xr[i]) ref_x[i] = xr[i] * 65536.0;
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    b_in      = '0;
    repeat (cycles) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_x_out", x_out, 0);
    check("rst_iters", iters, 0);
    check("rst_converged", converged, 0);
    reset = 1'b0;
  endtask

  // Feed b with `gap` idle cycles between samples, then `extra` junk beats
  task automatic load_b(input int gap, input int extra);
    int cnt = 0;
    int cyc = 0;
    int gapc = 0;
    while (cnt < N && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (gapc > 0) begin
        in_valid = 1'b0;
        gapc--;
      end else begin
        in_valid = 1'b1;
        b_in     = 16'(b_arr[cnt]);
        if (in_ready) begin
          cnt++;
          gapc = gap;
        end
      end
    end
    check("load_count", cnt, N);
    for (int e = 0; e <= extra; e++) begin
      @(negedge clk);
      check("calc_in_ready", in_ready, 0);
      check("calc_out_valid", out_valid, 0);
      b_in     = 16'($urandom);
      in_valid = (e < extra);
    end
  endtask

  task automatic collect(input int stall_pct);
    int beat = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic signed [31:0] px = '0;
    logic pl = 1'b0;
    real diff;
    while (beat < N && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_x", x_out, px);
        check("stall_last", out_last, pl);
      end
      out_ready  = ($urandom_range(99) >= stall_pct);
      prev_stall = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          check($sformatf("x[%0d]", beat), x_out, exp_x[beat]);
          check($sformatf("last[%0d]", beat), out_last, (beat == N - 1) ? 1 : 0);
          check($sformatf("iters[%0d]", beat), iters, exp_iters);
          check($sformatf("conv[%0d]", beat), converged, exp_conv);
          if (use_ref) begin
            diff = real'(x_out) - ref_x[beat];
            check($sformatf("near_ref[%0d]", beat), (diff <= 2.0 && diff >= -2.0) ? 1 : 0, 1);
          end
          beat++;
        end else begin
          prev_stall = 1'b1;
          px = x_out;
          pl = out_last;
        end
      end
    end
    check("beats", beat, N);
    @(negedge clk);
    check("post_send_valid", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    do_reset(3);

    // All-zero b: one sweep, no change
    foreach (b_arr[i]) b_arr[i] = 0;
    model_solve();
    load_b(0, 0);
    collect(0);

    // Impulse at b_0
    foreach (b_arr[i]) b_arr[i] = 0;
    b_arr[0] = 20;
    model_solve();
    load_b(0, 0);
    collect(0);

    // Constant b = 20, also against the real-valued solve
    foreach (b_arr[i]) b_arr[i] = 20;
    model_solve();
    ref_solve();
    use_ref = 1'b1;
    load_b(0, 0);
    collect(0);
    use_ref = 1'b0;

    // Full-range random b, gapped load, junk in_valid during CALC, stalls
    foreach (b_arr[i]) b_arr[i] = int'($signed(16'($urandom)));
    model_solve();
    load_b(3, 5);
    collect(50);

    // Small random b, back-to-back load, stalls
    foreach (b_arr[i]) b_arr[i] = $urandom_range(200) - 100;
    model_solve();
    load_b(0, 2);
    collect(50);

    // Abort during the sweep-3 WRITE of x_5, then a fresh solve
    foreach (b_arr[i]) b_arr[i] = int'($signed(16'($urandom)));
    load_b(0, 0);
    repeat (2 * (N * (DIV_LAT + 2) + 1) + 5 * (DIV_LAT + 2) + DIV_LAT + 1) @(negedge clk);
    do_reset(2);
    foreach (b_arr[i]) b_arr[i] = $urandom_range(2000) - 1000;
    model_solve();
    load_b(1, 0);
    collect(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
